// File: rtl/CPU_profile.sv
// CPU_profile: shared data width, AXI response codes and the imem responder state type.
`default_nettype none

package CPU_profile;

  localparam int XLEN = 32;

  typedef enum logic [1:0] {
    OKAY   = 2'b00,
    SLVERR = 2'b10
  } resp_t;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    WAIT = 2'b01,
    RESP = 2'b10
  } state_t;

  // True for a misaligned fetch or one beyond the end of the array.
  function automatic logic addr_bad(input logic [XLEN-1:0] addr, input int unsigned depth_words);
    logic [XLEN:0] lim;
    lim = (XLEN+1)'(depth_words) << 2;
    return (addr[1:0] != 2'b00) || ({1'b0, addr} >= lim);
  endfunction

endpackage

`default_nettype wire

// File: rtl/imem_array.sv
// imem_array: instruction word storage, one registered read port and one write port, no reset.
`default_nettype none

module imem_array
  import CPU_profile::*;
#(
  parameter int DEPTH = 1024,
  parameter int AW    = 10
) (
  input  logic            clk,
  input  logic            rd_en,
  input  logic [AW-1:0]   rd_idx,
  output logic [XLEN-1:0] rd_data,
  input  logic            we,
  input  logic [AW-1:0]   wr_idx,
  input  logic [XLEN-1:0] wr_data
);

  logic [XLEN-1:0] mem [DEPTH];

  // Read and write share one edge; the read sees the pre-write word.
  always_ff @(posedge clk) begin
    if (we)
      mem[wr_idx] <= wr_data;
    if (rd_en)
      rd_data <= mem[rd_idx];
  end

endmodule

`default_nettype wire

// File: rtl/imem_axi_rsp.sv
// imem_axi_rsp: AXI read-only instruction memory responder with LAT-cycle fetch latency.
// Optional IMEM_ADDR_CHECK_EN returns SLVERR/zero data for misaligned or out-of-range fetches.
`default_nettype none

module imem_axi_rsp
  import CPU_profile::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int LAT         = 1
) (
  input  logic            ACLK,
  input  logic            ARESETn,
  input  logic [XLEN-1:0] ARADDR,
  input  logic            ARVALID,
  output logic            ARREADY,
  output logic [XLEN-1:0] RDATA,
  output logic [1:0]      RRESP,
  output logic            RVALID,
  input  logic            RREADY,
  input  logic            prog_we,
  input  logic [XLEN-1:0] prog_addr,
  input  logic [XLEN-1:0] prog_wdata
);

  localparam int         AW       = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [3:0] CNT_INIT = 4'(LAT - 1);

  state_t          state;
  logic [3:0]      cnt;
  logic [XLEN-1:0] addr_q;
  logic            zero_q;
  resp_t           resp_q;
  logic            rdy_en;

  logic            ar_hs;
  logic            r_hs;
  logic            rd_en;
  logic [XLEN-1:0] rd_addr;
  logic            rd_bad;
  logic [XLEN-1:0] mem_q;

  assign ARREADY = rdy_en & ((state == IDLE) | ((state == RESP) & RREADY));
  assign RVALID  = (state == RESP);
  assign ar_hs   = ARVALID & ARREADY;
  assign r_hs    = RVALID & RREADY;

  // The array is sampled on the edge that enters RESP; with LAT=1 that is the AR edge itself.
  assign rd_en   = (ar_hs && (LAT == 1)) || ((state == WAIT) && (cnt == 4'd1));
  assign rd_addr = (state == WAIT) ? addr_q : ARADDR;

`ifdef IMEM_ADDR_CHECK_EN
  assign rd_bad = addr_bad(rd_addr, DEPTH_WORDS);
`else
  assign rd_bad = 1'b0;
`endif

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      state  <= IDLE;
      cnt    <= 4'd0;
      addr_q <= '0;
      zero_q <= 1'b1;
      resp_q <= OKAY;
      rdy_en <= 1'b0;
    end else begin
      rdy_en <= 1'b1;
      if (rd_en) begin
        zero_q <= rd_bad;
        resp_q <= rd_bad ? SLVERR : OKAY;
      end
      case (state)
        IDLE: begin
          if (ar_hs) begin
            addr_q <= ARADDR;
            cnt    <= CNT_INIT;
            state  <= (LAT == 1) ? RESP : WAIT;
          end
        end
        WAIT: begin
          cnt <= cnt - 4'd1;
          if (cnt == 4'd1)
            state <= RESP;
        end
        RESP: begin
          if (ar_hs) begin
            addr_q <= ARADDR;
            cnt    <= CNT_INIT;
            state  <= (LAT == 1) ? RESP : WAIT;
          end else if (r_hs) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  imem_array #(
    .DEPTH (DEPTH_WORDS),
    .AW    (AW)
  ) u_array (
    .clk     (ACLK),
    .rd_en   (rd_en),
    .rd_idx  (rd_addr[AW+1:2]),
    .rd_data (mem_q),
    .we      (prog_we),
    .wr_idx  (prog_addr[AW+1:2]),
    .wr_data (prog_wdata)
  );

  // Zero data is forced after reset and for rejected fetches.
  assign RDATA = zero_q ? '0 : mem_q;
  assign RRESP = resp_q;

  wire unused_addr_bits = ^{ARADDR, prog_addr, addr_q};

endmodule

`default_nettype wire

// File: tb/tb_imem_axi_rsp.sv
// Bench for imem_axi_rsp: three instances (LAT 1, 3, 4) with a queue-based response scoreboard.
`default_nettype none

module tb_imem_axi_rsp;
  import CPU_profile::*;

  localparam logic [1:0] OK = 2'b00;
  localparam logic [1:0] SE = 2'b10;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        aresetn [3];
  logic        arvalid [3];
  logic        rready  [3];
  logic        prog_we [3];
  logic [31:0] araddr  [3];
  logic [31:0] prog_addr  [3];
  logic [31:0] prog_wdata [3];
  logic        arready [3];
  logic        rvalid  [3];
  logic [31:0] rdata   [3];
  logic [1:0]  rresp   [3];

  logic [33:0] exp_q [3][$];
  int total = 0;
  int bad   = 0;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int L = (g == 0) ? 1 : ((g == 1) ? 3 : 4);
    imem_axi_rsp #(.DEPTH_WORDS(1024), .LAT(L)) u_dut (
      .ACLK       (clk),
      .ARESETn    (aresetn[g]),
      .ARADDR     (araddr[g]),
      .ARVALID    (arvalid[g]),
      .ARREADY    (arready[g]),
      .RDATA      (rdata[g]),
      .RRESP      (rresp[g]),
      .RVALID     (rvalid[g]),
      .RREADY     (rready[g]),
      .prog_we    (prog_we[g]),
      .prog_addr  (prog_addr[g]),
      .prog_wdata (prog_wdata[g])
    );
  end

  task automatic check(string name, logic [63:0] act, logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic monitor();
    forever begin
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
        if (rvalid[i] === 1'b1 && rready[i] === 1'b1) begin
          if (exp_q[i].size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_rsp dut%0d: got %0h, required none", i, {rresp[i], rdata[i]});
          end else begin
            check($sformatf("rsp dut%0d", i), {30'd0, rresp[i], rdata[i]}, {30'd0, exp_q[i].pop_front()});
          end
        end
      end
    end
  endtask

  // Called right after a rising edge; returns right after the AR handshake edge.
  task automatic send(int i, logic [31:0] a, logic [33:0] e, bit push);
    int   n;
    logic hs;
    n  = 0;
    hs = 1'b0;
    arvalid[i] = 1'b1;
    araddr[i]  = a;
    if (push) exp_q[i].push_back(e);
    while (!hs && n < 50) begin
      @(negedge clk);
      hs = arready[i];
      tick();
      n++;
    end
    if (!hs) begin
      total++;
      bad++;
      $display("FAIL ar_timeout dut%0d: got no handshake, required handshake", i);
    end
    arvalid[i] = 1'b0;
  endtask

  task automatic prog(int i, logic [31:0] a, logic [31:0] d);
    prog_we[i]    = 1'b1;
    prog_addr[i]  = a;
    prog_wdata[i] = d;
    tick();
    prog_we[i] = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((exp_q[0].size() + exp_q[1].size() + exp_q[2].size()) != 0 && n < 60) begin
      tick();
      n++;
    end
    if (n >= 60) begin
      total++;
      bad++;
      $display("FAIL drain_timeout: got %0d pending, required 0", exp_q[0].size() + exp_q[1].size() + exp_q[2].size());
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    for (int i = 0; i < 3; i++) begin
      aresetn[i] = 1'b0; arvalid[i] = 1'b0; rready[i] = 1'b1; prog_we[i] = 1'b0;
      araddr[i] = '0; prog_addr[i] = '0; prog_wdata[i] = '0;
    end
    fork monitor(); join_none

    tick(); tick(); tick();
    @(negedge clk);
    check("reset_state", {rvalid[0], rresp[0], rdata[0]}, 64'd0);
    check("reset_state_lat3", {rvalid[1], rresp[1], rdata[1]}, 64'd0);
    tick();
    for (int i = 0; i < 3; i++) aresetn[i] = 1'b1;
    tick();
    @(negedge clk);
    check("arready_after_reset", {63'd0, arready[0]}, 64'd1);
    tick();

    prog(0, 32'h0, 32'h0000_0013);
    prog(0, 32'h4, 32'h0050_0093);
    prog(0, 32'h8, 32'h1111_1111);
    prog(1, 32'h8, 32'h0000_2222);
    prog(1, 32'hC, 32'h3333_3333);
    prog(2, 32'h14, 32'h0000_0055);

    // Back-to-back fetches at LAT=1.
    send(0, 32'h0, {OK, 32'h0000_0013}, 1'b1);
    send(0, 32'h4, {OK, 32'h0050_0093}, 1'b1);
    @(negedge clk);
    check("a_consecutive_rvalid", {63'd0, rvalid[0]}, 64'd1);
    tick();
    drain();

    // Address handling: misaligned, out of range, wrapped.
`ifdef IMEM_ADDR_CHECK_EN
    send(0, 32'h2,    {SE, 32'h0}, 1'b1);
    send(0, 32'h1000, {SE, 32'h0}, 1'b1);
    send(0, 32'h1004, {SE, 32'h0}, 1'b1);
`else
    send(0, 32'h2,    {OK, 32'h0000_0013}, 1'b1);
    send(0, 32'h1000, {OK, 32'h0000_0013}, 1'b1);
    send(0, 32'h1004, {OK, 32'h0050_0093}, 1'b1);
`endif
    drain();

    // Backdoor write colliding with the sampling edge.
    prog_we[0] = 1'b1; prog_addr[0] = 32'h8; prog_wdata[0] = 32'hDEAD_BEEF;
    send(0, 32'h8, {OK, 32'h1111_1111}, 1'b1);
    prog_we[0] = 1'b0;
    send(0, 32'h8, {OK, 32'hDEAD_BEEF}, 1'b1);
    drain();

    // LAT=3 timing.
    send(1, 32'h8, {OK, 32'h0000_2222}, 1'b1);
    @(negedge clk);
    check("b_wait1", {62'd0, arready[1], rvalid[1]}, 64'd0);
    @(negedge clk);
    check("b_wait2", {62'd0, arready[1], rvalid[1]}, 64'd0);
    @(negedge clk);
    check("b_rvalid_3rd_edge", {63'd0, rvalid[1]}, 64'd1);
    tick();
    drain();

    // Backpressure in RESP.
    rready[1] = 1'b0;
    send(1, 32'hC, {OK, 32'h3333_3333}, 1'b1);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (rvalid[1] !== 1'b1 && n < 20);
    for (int k = 0; k < 5; k++) begin
      check("c_hold", {28'd0, rvalid[1], arready[1], rresp[1], rdata[1]}, {28'd0, 1'b1, 1'b0, OK, 32'h3333_3333});
      @(negedge clk);
    end
    tick();
    rready[1] = 1'b1;
    tick();
    @(negedge clk);
    check("c_idle", {62'd0, rvalid[1], arready[1]}, 64'd1);
    check("c_one_handshake", 64'(exp_q[1].size()), 64'd0);
    tick();

    // Reset during WAIT discards the pending fetch; contents survive.
    rready[2] = 1'b1;
    send(2, 32'h14, 34'd0, 1'b0);
    tick();
    aresetn[2] = 1'b0;
    tick();
    aresetn[2] = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      check("e_no_rvalid", {63'd0, rvalid[2]}, 64'd0);
    end
    tick();
    send(2, 32'h14, {OK, 32'h0000_0055}, 1'b1);
    drain();
    tick(); tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/imem_axi_rsp.md
IMEM_AXI_RSP -- requirements
Module: imem_axi_rsp

Interface
REQ-001 Parameters SHALL be: DEPTH_WORDS, default 1024, number of 32-bit words; LAT, default 1, legal range 1..15, number of cycles from AR handshake to RVALID.
REQ-002 ACLK  input  1  clock; all state updates on the rising edge.
REQ-003 ARESETn  input  1  reset, asynchronous, active-low.
REQ-004 ARADDR  input  XLEN  byte address of the fetch.
REQ-005 ARVALID  input  1  fetch request valid.
REQ-006 ARREADY  output  1  request accepted when ARVALID and ARREADY are both high.
REQ-007 RDATA  output  XLEN  instruction word.
REQ-008 RRESP  output  2  response code: 2'b00 OKAY, 2'b10 SLVERR.
REQ-009 RVALID  output  1  response valid.
REQ-010 RREADY  input  1  response consumed when RVALID and RREADY are both high.
REQ-011 prog_we  input  1  backdoor word write enable, for program load.
REQ-012 prog_addr  input  XLEN  backdoor byte address; bits [1:0] are ignored.
REQ-013 prog_wdata  input  XLEN  backdoor write data.

Function
REQ-014 FSM states SHALL be IDLE, WAIT and RESP.
REQ-015 IDLE: ARREADY=1 and RVALID=0; an AR handshake latches ARADDR and loads cnt=LAT-1, then goes to RESP if LAT=1, else to WAIT.
REQ-016 WAIT: ARREADY=0; cnt decrements each cycle; when cnt=1 the next state is RESP.
REQ-017 RVALID SHALL rise exactly LAT cycles after the AR handshake edge, together with RDATA and RRESP.
REQ-018 RESP: RVALID=1; RDATA and RRESP SHALL hold stable until the R handshake.
REQ-019 RESP: ARREADY SHALL equal RREADY.
REQ-020 RESP, R and AR handshakes in the same cycle: the new request is latched and the FSM goes to RESP (LAT=1) or WAIT; otherwise an R handshake returns the FSM to IDLE.
REQ-021 Throughput SHALL be one response per cycle when LAT=1 and RREADY is held high.
REQ-022 The read word index SHALL be latched_addr[log2(DEPTH_WORDS)+1:2]; higher address bits wrap modulo the array depth.
REQ-023 The array SHALL be sampled on the edge entering RESP; RDATA is registered.
REQ-024 A prog_we write to the word being sampled on the same edge: the read SHALL return the old word and the write SHALL complete.
REQ-025 prog_we SHALL be accepted in every state and SHALL never stall the AXI channels.
REQ-026 An AR request arriving while ARREADY=0 SHALL be held by the initiator; the block takes no action on it.

Reset
REQ-027 On ARESETn low, the FSM SHALL go to IDLE, cnt=0, RVALID=0, RDATA=0, RRESP=OKAY; ARREADY becomes 1 after reset deasserts.
REQ-028 Reset during WAIT or RESP SHALL discard the pending response; no RVALID is issued for it.
REQ-029 Array contents SHALL NOT be reset.

Configuration
REQ-030 With IMEM_ADDR_CHECK_EN defined, SLVERR and RDATA=0 SHALL be returned when ARADDR[1:0]!=0 or ARADDR>=DEPTH_WORDS*4; the timing is unchanged.
REQ-031 Without IMEM_ADDR_CHECK_EN, RRESP SHALL always be OKAY, bits [1:0] are ignored, and addresses wrap.

Structure
REQ-032 XLEN, the resp_t enum (OKAY, SLVERR) and the FSM state typedef SHALL live in CPU_profile.
REQ-033 Storage SHALL be the sub-module imem_array: one synchronous read port, one synchronous write port, no reset.
REQ-034 The FSM, counter and address check SHALL stay in imem_axi_rsp.

Verification
REQ-035 LAT=1; preload word 0=0x00000013 and word 1=0x00500093; ARADDR=0x0 then 0x4 back-to-back with RREADY=1 -> RDATA 0x00000013 then 0x00500093 on consecutive cycles, RRESP=OKAY.
REQ-036 LAT=3; one request to 0x8 -> RVALID rises on the 3rd edge after the handshake; ARREADY=0 for the two intervening cycles.
REQ-037 RREADY=0 for 5 cycles in RESP -> RVALID, RDATA and RRESP stable; ARREADY=0; after RREADY=1, one handshake, then IDLE.
REQ-038 prog_we to word 2 (0xDEADBEEF, old value 0x11111111) on the sampling edge of a read to 0x8 -> 0x11111111 returned; the next read returns 0xDEADBEEF.
REQ-039 ARESETn pulsed low during WAIT (LAT=4) -> no RVALID afterwards; the next request completes normally.
REQ-040 IMEM_ADDR_CHECK_EN defined: ARADDR=0x2 and 0x1000 (DEPTH_WORDS=1024) -> SLVERR and RDATA=0; undefined: OKAY, with words 0 and 0 returned.
